weight_stream_reader: RTL

- Read-side controller for the 16x8 weight buffer SRAM (active-low chip select, write enable and output enable).
- On a start command it issues a sequence of SRAM reads, with optional address wrap and repeated passes.
- Returns the signed 8-bit weights to the ternary/accumulate datapath as a valid/ready stream with last-word marking.
- Absorbs the SRAM's one-cycle read latency and downstream backpressure with a 2-entry output FIFO.

---
 rtl/weight_stream_reader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/weight_stream_reader.sv
// Read-side controller for the 16x8 weight buffer SRAM: issues address sequences with
// wrap and repeated passes, and streams the signed weights out through a 2-entry FIFO.
module weight_stream_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          length,
    input  logic [3:0]               rep,
    output logic                     sram_csb,
    output logic                     sram_web,
    output logic                     sram_oeb,
    output logic [ADDR_W-1:0]        sram_addr,
    input  logic signed [DATA_W-1:0] sram_rdata,
    output logic                     w_valid,
    input  logic                     w_ready,
    output logic signed [DATA_W-1:0] w_data,
    output logic                     w_last,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [ADDR_W:0]   pass_pos_q;
    logic [8:0]        words_left_q;
    logic [8:0]        total_words;
    logic [ADDR_W:0]   len_m1;

    logic inflight_q;
    logic inflight_last_q;

    logic signed [DATA_W-1:0] fifo_data [2];
    logic                     fifo_last [2];
    logic                     rd_ptr_q;
    logic                     wr_ptr_q;
    logic [1:0]               fifo_count_q;

    logic       start_accept;
    logic       push;
    logic       pop;
    logic [2:0] occupancy;
    logic       issue;
    logic       final_read;

    assign start_accept = (state_q == S_IDLE) && start;
    assign total_words  = 9'(length) * (9'(rep) + 9'd1);
    assign len_m1       = len_q - {{ADDR_W{1'b0}}, 1'b1};
    assign final_read   = (words_left_q == 9'd1);

    assign push      = inflight_q;
    assign pop       = w_valid && w_ready;
    assign occupancy = {1'b0, fifo_count_q} + {2'b00, inflight_q};

    // A word popped this cycle frees its slot in time for a read issued now.
    assign issue = (state_q == S_ISSUE) &&
                   ((occupancy < 3'd2) || ((occupancy == 3'd2) && pop));

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue && final_read) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && w_last) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address walk: advances per issued read, reloading base_q at the end of each pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q          <= '0;
            len_q           <= '0;
            cur_addr_q      <= '0;
            pass_pos_q      <= '0;
            words_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && final_read;
            if (start_accept) begin
                base_q       <= base_addr;
                len_q        <= length;
                cur_addr_q   <= base_addr;
                pass_pos_q   <= '0;
                words_left_q <= total_words;
            end else if (issue) begin
                words_left_q <= words_left_q - 9'd1;
                if (pass_pos_q == len_m1) begin
                    pass_pos_q <= '0;
                    cur_addr_q <= base_q;
                end else begin
                    pass_pos_q <= pass_pos_q + {{ADDR_W{1'b0}}, 1'b1};
                    cur_addr_q <= cur_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // NOTE: the two FIFO slots are reset as well; they are tiny, and clearing them
    // keeps w_data/w_last deterministic after an aborted command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            fifo_count_q <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr_q] <= sram_rdata;
                fifo_last[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
                2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    assign sram_csb  = ~issue;
    assign sram_web  = 1'b1;
    assign sram_oeb  = 1'b0;
    assign sram_addr = cur_addr_q;

    assign w_valid = (fifo_count_q != 2'd0);
    assign w_data  = w_valid ? fifo_data[rd_ptr_q] : '0;
    assign w_last  = w_valid && fifo_last[rd_ptr_q];

    assign busy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done = (state_q == S_FINISH);

endmodule
